// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: upstream (s_*) and downstream (m_*) AXI read bundle; QoS signals exist under AXI_RD_ARB_QOS_EN
interface axi_rd_arbiter_if #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 64
);
    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    logic [NUM_MST-1:0]        s_arvalid;
    logic [NUM_MST-1:0]        s_arready;
    logic [NUM_MST*ADDR_W-1:0] s_araddr;
    logic [NUM_MST*ID_W-1:0]   s_arid;
    logic [NUM_MST*8-1:0]      s_arlen;
    logic [NUM_MST*3-1:0]      s_arsize;
    logic [NUM_MST*2-1:0]      s_arburst;
    logic [NUM_MST-1:0]        s_rvalid;
    logic [NUM_MST-1:0]        s_rready;
    logic [DATA_W-1:0]         s_rdata;
    logic [ID_W-1:0]           s_rid;
    logic [1:0]                s_rresp;
    logic                      s_rlast;
    logic                      m_arvalid;
    logic                      m_arready;
    logic [ADDR_W-1:0]         m_araddr;
    logic [ID_W+IDX_W-1:0]     m_arid;
    logic [7:0]                m_arlen;
    logic [2:0]                m_arsize;
    logic [1:0]                m_arburst;
    logic                      m_rvalid;
    logic                      m_rready;
    logic [DATA_W-1:0]         m_rdata;
    logic [ID_W+IDX_W-1:0]     m_rid;
    logic [1:0]                m_rresp;
    logic                      m_rlast;
    logic                      err_rid;
`ifdef AXI_RD_ARB_QOS_EN
    logic [NUM_MST*4-1:0]      s_arqos;
    logic [3:0]                m_arqos;
`endif
    // arbiter side
    modport slave (
        input  s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
        input  m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
        output s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        output m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready, err_rid
`ifdef AXI_RD_ARB_QOS_EN
        , input s_arqos, output m_arqos
`endif
    );
    // environment side: requesters plus downstream slave
    modport master (
        output s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
        output m_arready, m_rvalid, m_rdata, m_rid, m_rresp, m_rlast,
        input  s_arready, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast,
        input  m_arvalid, m_araddr, m_arid, m_arlen, m_arsize, m_arburst, m_rready, err_rid
`ifdef AXI_RD_ARB_QOS_EN
        , output s_arqos, input m_arqos
`endif
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port with index-tagged ARID routing, outstanding limits; QoS via AXI_RD_ARB_QOS_EN
module axi_rd_arbiter #(
    parameter int NUM_MST  = 2,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 64,
    parameter int MAX_OUTS = 4
) (
    input logic             aclk,
    input logic             arst,
    axi_rd_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int MID_W = ID_W + IDX_W;
    typedef enum logic {EMPTY, FULL} state_t;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, win, idx;
    logic [3:0]        cnt_q [NUM_MST];
    logic [3:0]        cnt_d [NUM_MST];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MID_W-1:0]  id_q, id_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic              found, grant, in_range, r_done;
`ifdef AXI_RD_ARB_QOS_EN
    logic [3:0]        qos_q, qos_d, best;
`endif
    assign idx      = bus.m_rid[MID_W-1:ID_W];
    assign in_range = int'(idx) < NUM_MST;
    assign r_done   = bus.m_rvalid && bus.m_rready && bus.m_rlast;
    // winner: first eligible requester scanning up from ptr; with QoS only a strictly higher level overrides RR order
    always_comb begin
        int j;
        j = 0;
        win = '0;
        found = 1'b0;
`ifdef AXI_RD_ARB_QOS_EN
        best = '0;
`endif
        for (int k = 0; k < NUM_MST; k++) begin
            j = (int'(ptr_q) + k) % NUM_MST;
`ifdef AXI_RD_ARB_QOS_EN
            if (bus.s_arvalid[j] && cnt_q[j] < 4'(MAX_OUTS) && (!found || bus.s_arqos[j*4 +: 4] > best)) begin
                best = bus.s_arqos[j*4 +: 4];
`else
            if (bus.s_arvalid[j] && cnt_q[j] < 4'(MAX_OUTS) && !found) begin
`endif
                found = 1'b1;
                win = IDX_W'(j);
            end
        end
    end
    // AR register: free when empty or draining this cycle; loads the winner's fields on a grant
    always_comb begin
        grant   = found && (state_q == EMPTY || bus.m_arready);
        state_d = grant ? FULL : (bus.m_arready ? EMPTY : state_q);
        ptr_d   = grant ? IDX_W'((int'(win) + 1) % NUM_MST) : ptr_q;
        addr_d  = grant ? bus.s_araddr[win*ADDR_W +: ADDR_W] : addr_q;
        id_d    = grant ? {win, bus.s_arid[win*ID_W +: ID_W]} : id_q;
        len_d   = grant ? bus.s_arlen[win*8 +: 8] : len_q;
        size_d  = grant ? bus.s_arsize[win*3 +: 3] : size_q;
        burst_d = grant ? bus.s_arburst[win*2 +: 2] : burst_q;
`ifdef AXI_RD_ARB_QOS_EN
        qos_d   = grant ? bus.s_arqos[win*4 +: 4] : qos_q;
`endif
        err_d   = err_q || (bus.m_rvalid && !in_range);
        for (int i = 0; i < NUM_MST; i++)
            cnt_d[i] = cnt_q[i] + 4'(grant && win == IDX_W'(i)) - 4'(r_done && idx == IDX_W'(i) && cnt_q[i] != 4'd0);
    end
    // R routing by index; beats with an unknown index are drained so the slave never stalls
    always_comb begin
        bus.s_arready = (grant && !arst) ? NUM_MST'(1) << win : '0;
        bus.s_rvalid  = '0;
        bus.m_rready  = !in_range;
        for (int i = 0; i < NUM_MST; i++) begin
            bus.s_rvalid[i] = bus.m_rvalid && idx == IDX_W'(i) && !arst;
            if (idx == IDX_W'(i)) bus.m_rready = bus.s_rready[i];
        end
    end
    assign bus.m_arvalid = state_q == FULL;
    assign bus.m_araddr  = addr_q;
    assign bus.m_arid    = id_q;
    assign bus.m_arlen   = len_q;
    assign bus.m_arsize  = size_q;
    assign bus.m_arburst = burst_q;
    assign bus.s_rdata   = DATA_W'(bus.m_rdata);
    assign bus.s_rid     = bus.m_rid[ID_W-1:0];
    assign bus.s_rresp   = bus.m_rresp;
    assign bus.s_rlast   = bus.m_rlast;
    assign bus.err_rid   = err_q;
`ifdef AXI_RD_ARB_QOS_EN
    assign bus.m_arqos   = qos_q;
`endif
    // state register; reset discards any in-flight AR and all outstanding counts
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
`ifdef AXI_RD_ARB_QOS_EN
            qos_q   <= '0;
`endif
            for (int i = 0; i < NUM_MST; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
`ifdef AXI_RD_ARB_QOS_EN
            qos_q   <= qos_d;
`endif
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: model-checked 2-requester arbiter plus directed checks on a 3-requester instance
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int DW = 64;
    localparam int MO = 4;
    logic clk = 1'b0;
    logic arst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.NUM_MST(2), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) ifa ();
    axi_rd_arbiter_if #(.NUM_MST(3), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW)) ifb ();
    axi_rd_arbiter #(.NUM_MST(2), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTS(MO)) dut_a (
        .aclk(clk), .arst(arst), .bus(ifa));
    axi_rd_arbiter #(.NUM_MST(3), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW), .MAX_OUTS(MO)) dut_b (
        .aclk(clk), .arst(arst), .bus(ifb));

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
    endtask

    task automatic set_ar(int i, logic [AW-1:0] addr, logic [IW-1:0] id, logic [7:0] len);
        ifa.s_araddr[i*AW +: AW] = addr;
        ifa.s_arid[i*IW +: IW]   = id;
        ifa.s_arlen[i*8 +: 8]    = len;
        ifa.s_arsize[i*3 +: 3]   = 3'd3;
        ifa.s_arburst[i*2 +: 2]  = 2'd1;
    endtask

    task automatic beat(logic [IW:0] rid, logic last, logic [DW-1:0] data);
        ifa.m_rvalid = 1'b1;
        ifa.m_rid    = rid;
        ifa.m_rlast  = last;
        ifa.m_rdata  = data;
        ifa.m_rresp  = 2'b00;
    endtask

    // Reference model of dut_a: outstanding bursts per requester, RR pointer, and the AR currently offered downstream.
    int           m_cnt [2];
    int           m_ptr;
    bit           m_full;
    logic [AW-1:0] e_addr;
    logic [IW:0]  e_id;
    logic [7:0]   e_len;
    logic [2:0]   e_size;
    logic [1:0]   e_burst;
    logic [3:0]   e_qos;
    always @(negedge clk) begin : model
        int w;
        int ri;
        int qv [2];
        bit free;
        logic [1:0] e_ar;
        logic [1:0] e_rv;
        logic e_rr;
        if (arst) begin
            m_cnt = '{0, 0};
            m_ptr = 0;
            m_full = 1'b0;
            chk("rst s_arready", ifa.s_arready, 0);
            chk("rst s_rvalid", ifa.s_rvalid, 0);
            chk("rst m_arvalid", ifa.m_arvalid, 0);
            chk("rst m_araddr", ifa.m_araddr, 0);
            chk("rst m_arid", ifa.m_arid, 0);
            chk("rst err_rid", ifa.err_rid, 0);
        end else begin
            qv = '{0, 0};
`ifdef AXI_RD_ARB_QOS_EN
            qv = '{int'(ifa.s_arqos[3:0]), int'(ifa.s_arqos[7:4])};
`endif
            w = -1;
            for (int k = 0; k < 2; k++) begin
                int j;
                j = (m_ptr + k) % 2;
                if (ifa.s_arvalid[j] && m_cnt[j] < MO && (w < 0 || qv[j] > qv[w])) w = j;
            end
            free = !m_full || ifa.m_arready;
            e_ar = (free && w >= 0) ? 2'(1 << w) : 2'b00;
            ri   = int'(ifa.m_rid[IW]);
            e_rv = ifa.m_rvalid ? 2'(1 << ri) : 2'b00;
            e_rr = ifa.s_rready[ri];
            chk("s_arready", ifa.s_arready, e_ar);
            chk("m_arvalid", ifa.m_arvalid, m_full);
            if (m_full) begin
                chk("m_araddr", ifa.m_araddr, e_addr);
                chk("m_arid", ifa.m_arid, e_id);
                chk("m_arlen", ifa.m_arlen, e_len);
                chk("m_arsize", ifa.m_arsize, e_size);
                chk("m_arburst", ifa.m_arburst, e_burst);
`ifdef AXI_RD_ARB_QOS_EN
                chk("m_arqos", ifa.m_arqos, e_qos);
`endif
            end
            chk("s_rvalid", ifa.s_rvalid, e_rv);
            chk("m_rready", ifa.m_rready, e_rr);
            chk("err_rid", ifa.err_rid, 0);
            if (ifa.m_rvalid) begin
                chk("s_rdata", ifa.s_rdata, ifa.m_rdata);
                chk("s_rid", ifa.s_rid, ifa.m_rid[IW-1:0]);
                chk("s_rlast", ifa.s_rlast, ifa.m_rlast);
                chk("s_rresp", ifa.s_rresp, ifa.m_rresp);
            end
            if (ifa.m_rvalid && e_rr && ifa.m_rlast && m_cnt[ri] > 0) m_cnt[ri]--;
            if (e_ar != 2'b00) begin
                m_cnt[w]++;
                m_ptr   = (w + 1) % 2;
                m_full  = 1'b1;
                e_addr  = ifa.s_araddr[w*AW +: AW];
                e_id    = {w[0], ifa.s_arid[w*IW +: IW]};
                e_len   = ifa.s_arlen[w*8 +: 8];
                e_size  = ifa.s_arsize[w*3 +: 3];
                e_burst = ifa.s_arburst[w*2 +: 2];
                e_qos   = 4'(qv[w]);
            end else if (ifa.m_arready) begin
                m_full = 1'b0;
            end
        end
    end

    initial begin
        logic [1:0] exp_gnt [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        ifa.s_arvalid = '0; ifa.s_araddr = '0; ifa.s_arid = '0; ifa.s_arlen = '0;
        ifa.s_arsize = '0; ifa.s_arburst = '0; ifa.s_rready = '0; ifa.m_arready = 1'b0;
        ifa.m_rvalid = 1'b0; ifa.m_rdata = '0; ifa.m_rid = '0; ifa.m_rresp = '0; ifa.m_rlast = 1'b0;
        ifb.s_arvalid = '0; ifb.s_araddr = '0; ifb.s_arid = '0; ifb.s_arlen = '0;
        ifb.s_arsize = '0; ifb.s_arburst = '0; ifb.s_rready = '0; ifb.m_arready = 1'b0;
        ifb.m_rvalid = 1'b0; ifb.m_rdata = '0; ifb.m_rid = '0; ifb.m_rresp = '0; ifb.m_rlast = 1'b0;
`ifdef AXI_RD_ARB_QOS_EN
        ifa.s_arqos = '0;
        ifb.s_arqos = '0;
`endif
        tick();
        tick();
        arst = 1'b0;

        // single request from requester 0 and its four-beat burst
        set_ar(0, 32'h1000, 4'h3, 8'd3);
        ifa.s_arvalid = 2'b01;
        ifa.m_arready = 1'b1;
        @(negedge clk);
        chk("t1 grant", ifa.s_arready, 2'b01);
        tick();
        ifa.s_arvalid = 2'b00;
        @(negedge clk);
        chk("t1 m_arvalid", ifa.m_arvalid, 1);
        chk("t1 m_arid", ifa.m_arid, 5'h03);
        chk("t1 m_araddr", ifa.m_araddr, 32'h1000);
        chk("t1 m_arlen", ifa.m_arlen, 8'd3);
        tick();
        ifa.s_rready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            beat(5'h03, b == 3, 64'hA0 + 64'(b));
            @(negedge clk);
            chk("t1 s_rvalid", ifa.s_rvalid, 2'b01);
            chk("t1 s_rdata", ifa.s_rdata, 64'hA0 + 64'(b));
            tick();
        end
        ifa.m_rvalid = 1'b0;
        ifa.s_rready = 2'b00;

        // both requesters continuously valid: strict alternation starting at 0
        do_reset();
        set_ar(0, 32'h100, 4'h1, 8'd0);
        set_ar(1, 32'h200, 4'h2, 8'd0);
        ifa.s_arvalid = 2'b11;
        ifa.m_arready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t2 grant", ifa.s_arready, exp_gnt[c]);
            if (c > 0) chk("t2 arid index", ifa.m_arid[IW], exp_gnt[c-1][1]);
            tick();
        end
        ifa.s_arvalid = 2'b00;

        // requester 1 reaches MAX_OUTS; one rlast frees a slot
        do_reset();
        set_ar(1, 32'h300, 4'h5, 8'd0);
        ifa.s_arvalid = 2'b10;
        ifa.m_arready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t3 fill", ifa.s_arready, 2'b10);
            tick();
        end
        set_ar(0, 32'h400, 4'h6, 8'd0);
        ifa.s_arvalid = 2'b11;
        @(negedge clk);
        chk("t3 req0 while req1 full", ifa.s_arready, 2'b01);
        tick();
        ifa.s_arvalid = 2'b10;
        @(negedge clk);
        chk("t3 req1 stalled", ifa.s_arready, 2'b00);
        tick();
        beat(5'h15, 1'b1, 64'hBEEF);
        ifa.s_rready = 2'b10;
        @(negedge clk);
        chk("t3 stalled during rlast", ifa.s_arready, 2'b00);
        chk("t3 rvalid to req1", ifa.s_rvalid, 2'b10);
        tick();
        ifa.m_rvalid = 1'b0;
        @(negedge clk);
        chk("t3 req1 released", ifa.s_arready, 2'b10);
        tick();
        ifa.s_arvalid = 2'b00;
        ifa.s_rready = 2'b00;

        // downstream backpressure: AR held stable, nobody else granted
        do_reset();
        set_ar(0, 32'h2000, 4'h7, 8'd1);
        ifa.s_arvalid = 2'b01;
        ifa.m_arready = 1'b0;
        @(negedge clk);
        chk("t4 grant", ifa.s_arready, 2'b01);
        tick();
        set_ar(0, 32'h5555, 4'h8, 8'd2);
        ifa.s_arvalid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4 hold addr", ifa.m_araddr, 32'h2000);
            chk("t4 hold id", ifa.m_arid, 5'h07);
            chk("t4 no grant", ifa.s_arready, 2'b00);
            tick();
        end
        ifa.m_arready = 1'b1;
        @(negedge clk);
        chk("t4 req1 after handshake", ifa.s_arready, 2'b10);
        tick();
        ifa.s_arvalid = 2'b00;

`ifdef AXI_RD_ARB_QOS_EN
        // higher QoS wins over RR order
        do_reset();
        ifa.s_arqos = {4'd9, 4'd2};
        ifa.s_arvalid = 2'b11;
        @(negedge clk);
        chk("qos grant", ifa.s_arready, 2'b10);
        tick();
        ifa.s_arvalid = 2'b00;
        @(negedge clk);
        chk("qos m_arqos", ifa.m_arqos, 4'd9);
        tick();
        ifa.s_arqos = '0;
`endif

        // three requesters: out-of-range index, sticky error, reset mid-burst
        ifb.s_araddr[2*AW +: AW] = 32'h7000;
        ifb.s_arid[2*IW +: IW] = 4'hA;
        ifb.s_arvalid = 3'b100;
        @(negedge clk);
        chk("t5 grant req2", ifb.s_arready, 3'b100);
        tick();
        ifb.s_arvalid = 3'b000;
        @(negedge clk);
        chk("t5 m_arvalid", ifb.m_arvalid, 1);
        chk("t5 m_arid", ifb.m_arid, 6'h2A);
        tick();
        ifb.m_rvalid = 1'b1;
        ifb.m_rid = 6'h35;
        @(negedge clk);
        chk("t5 drain bad idx", ifb.m_rready, 1);
        chk("t5 no s_rvalid", ifb.s_rvalid, 3'b000);
        tick();
        ifb.m_rvalid = 1'b0;
        @(negedge clk);
        chk("t5 err set", ifb.err_rid, 1);
        tick();
        @(negedge clk);
        chk("t5 err sticky", ifb.err_rid, 1);
        tick();
        ifb.s_arvalid = 3'b111;
        ifb.m_rvalid = 1'b1;
        ifb.m_rid = 6'h2A;
        ifb.s_rready = 3'b100;
        arst = 1'b1;
        #1;
        chk("t5 rst m_arvalid", ifb.m_arvalid, 0);
        chk("t5 rst m_araddr", ifb.m_araddr, 0);
        chk("t5 rst m_arid", ifb.m_arid, 0);
        chk("t5 rst err", ifb.err_rid, 0);
        chk("t5 rst s_arready", ifb.s_arready, 3'b000);
        chk("t5 rst s_rvalid", ifb.s_rvalid, 3'b000);
        tick();
        ifb.m_rvalid = 1'b0;
        ifb.s_rready = 3'b000;
        arst = 1'b0;
        @(negedge clk);
        chk("t5 post-reset grant", ifb.s_arready, 3'b001);
        tick();
        ifb.s_arvalid = 3'b000;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
